// File: rtl/mux_8x1_rr_sched.sv
// Round-robin scheduler driving the select of a shared 8:1 mux.
// Each grant lasts at most HOLD cycles; priority rotates to the source after the last owner.
module mux_8x1_rr_sched #(
    parameter int HOLD = 4,
    parameter int CNTW = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       gnt_vld
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [CNTW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [2:0]        sel_q, sel_d;
    logic [7:0]        gnt_q, gnt_d;
    logic              gnt_vld_q, gnt_vld_d;

    logic [2:0]        arb_ptr;
    logic [15:0]       dbl;
    logic [7:0]        rot;
    logic [2:0]        pick;
    logic [2:0]        win;
    logic              release_grant;

    // On release the new priority starts right after the current owner, so arbitrate from there.
    always_comb begin
        arb_ptr = (state_q == GRANT) ? sel_q + 3'd1 : ptr_q;
        dbl     = {req, req} >> arb_ptr;
        rot     = dbl[7:0];
        pick    = 3'd0;
        for (int j = 7; j >= 0; j--) begin
            if (rot[j]) pick = 3'(j);
        end
        win = arb_ptr + pick;
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        sel_d         = sel_q;
        gnt_d         = gnt_q;
        gnt_vld_d     = gnt_vld_q;
        release_grant = (state_q == GRANT) &&
                        (!req[sel_q] || hold_cnt_q == CNTW'(HOLD) || !en);
        if (state_q == IDLE) begin
            if (en && |req) begin
                state_d    = GRANT;
                sel_d      = win;
                gnt_d      = 8'b1 << win;
                gnt_vld_d  = 1'b1;
                hold_cnt_d = CNTW'(1);
            end
        end else if (release_grant) begin
            ptr_d = sel_q + 3'd1;
            if (en && |req) begin
                sel_d      = win;
                gnt_d      = 8'b1 << win;
                gnt_vld_d  = 1'b1;
                hold_cnt_d = CNTW'(1);
            end else begin
                state_d    = IDLE;
                gnt_d      = 8'h00;
                gnt_vld_d  = 1'b0;
                hold_cnt_d = '0;
            end
        end else begin
            hold_cnt_d = hold_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 3'd0;
            hold_cnt_q <= '0;
            sel_q      <= 3'd0;
            gnt_q      <= 8'h00;
            gnt_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            gnt_vld_q  <= gnt_vld_d;
        end
    end

    assign sel     = sel_q;
    assign gnt     = gnt_q;
    assign gnt_vld = gnt_vld_q;
endmodule

// File: tb/tb_mux_8x1_rr_sched.sv
// Randomized + directed bench for mux_8x1_rr_sched; two instances (HOLD=4, HOLD=1)
// are tracked by an owner/pointer/count model and checked every cycle.
module tb_mux_8x1_rr_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] req = 8'hFF;
    logic [2:0] sel4, sel1;
    logic [7:0] gnt4, gnt1;
    logic       vld4, vld1;
    logic [7:0] iv = 8'hA7;

    int total = 0;
    int bad = 0;

    int own [2];
    int mptr[2];
    int mcnt[2];
    int msel[2];
    int hold[2] = '{4, 1};

    always #5 clk = ~clk;

    mux_8x1_rr_sched #(.HOLD(4), .CNTW(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .sel(sel4), .gnt(gnt4), .gnt_vld(vld4));
    mux_8x1_rr_sched #(.HOLD(1), .CNTW(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .sel(sel1), .gnt(gnt1), .gnt_vld(vld1));

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int arb(input int p, input logic [7:0] r);
        for (int j = 0; j < 8; j++)
            if (r[(p + j) % 8]) return (p + j) % 8;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            own[i] = -1; mptr[i] = 0; mcnt[i] = 0; msel[i] = 0;
        end
    endtask

    task automatic model_step();
        int k;
        for (int i = 0; i < 2; i++) begin
            if (own[i] >= 0 && req[own[i]] && en && mcnt[i] < hold[i]) begin
                mcnt[i]++;
            end else begin
                if (own[i] >= 0) mptr[i] = (own[i] + 1) % 8;
                k = en ? arb(mptr[i], req) : -1;
                own[i] = k;
                mcnt[i] = (k >= 0) ? 1 : 0;
                if (k >= 0) msel[i] = k;
            end
        end
    endtask

    task automatic compare_one(input int i, input logic [2:0] s, input logic [7:0] g,
                               input logic v);
        string tag;
        tag = (i == 0) ? "h4" : "h1";
        check({tag, "_sel"}, int'(s), msel[i]);
        check({tag, "_gnt"}, int'(g), (own[i] >= 0) ? (1 << own[i]) : 0);
        check({tag, "_vld"}, int'(v), (own[i] >= 0) ? 1 : 0);
        check({tag, "_onehot0"}, int'($onehot0(g)), 1);
        check({tag, "_vld_or"}, int'(v), int'(|g));
        if (v) begin
            check({tag, "_gnt_sel"}, int'(g[s]), 1);
            check({tag, "_mux_out"}, int'(iv[s]), int'(|(iv & g)));
        end
    endtask

    task automatic compare_all();
        compare_one(0, sel4, gnt4, vld4);
        compare_one(1, sel1, gnt1, vld1);
    endtask

    task automatic step(input logic [7:0] r, input logic e);
        req = r;
        en  = e;
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse_reset(input logic [7:0] r);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_gnt4", int'(gnt4), 0);
        check("async_rst_vld4", int'(vld4), 0);
        check("async_rst_sel4", int'(sel4), 0);
        check("async_rst_gnt1", int'(gnt1), 0);
        step(r, 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        // reset with all requests high
        #3;
        check("rst_sel", int'(sel4), 0);
        check("rst_gnt", int'(gnt4), 0);
        check("rst_vld", int'(vld4), 0);
        @(negedge clk);
        step(8'hFF, 1'b1);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) step(8'h00, 1'b1);
        check("idle_no_req", int'(vld4), 0);

        // single requester held
        pulse_reset(8'h00);
        step(8'h20, 1'b1);
        check("single_sel", int'(sel4), 5);
        check("single_gnt", int'(gnt4), 8'h20);
        for (int c = 0; c < 11; c++) begin
            step(8'h20, 1'b1);
            check("single_hold_vld", int'(vld4), 1);
        end

        // full rotation, 4 cycles per source
        pulse_reset(8'h00);
        for (int c = 0; c < 36; c++) begin
            step(8'hFF, 1'b1);
            check("rot_sel", int'(sel4), (c / 4) % 8);
            check("rot_vld", int'(vld4), 1);
        end

        // wrap 7 -> 0 -> 7
        pulse_reset(8'h00);
        step(8'h40, 1'b1);
        step(8'h80, 1'b1);
        check("wrap_sel7", int'(sel4), 7);
        for (int c = 0; c < 4; c++) step(8'h81, 1'b1);
        check("wrap_sel0", int'(sel4), 0);
        for (int c = 0; c < 4; c++) step(8'h81, 1'b1);
        check("wrap_back7", int'(sel4), 7);

        // early drop, then HOLD=1 alternation
        pulse_reset(8'h00);
        step(8'h44, 1'b1);
        check("drop_sel2", int'(sel4), 2);
        step(8'h44, 1'b1);
        step(8'h40, 1'b1);
        check("drop_sel6", int'(sel4), 6);
        check("drop_gnt", int'(gnt4), 8'h40);
        pulse_reset(8'h00);
        for (int c = 0; c < 8; c++) begin
            step(8'h05, 1'b1);
            check("h1_alt", int'(sel1), (c % 2) * 2);
        end

        // en drop mid-grant, reset mid-grant
        step(8'hFF, 1'b1);
        step(8'hFF, 1'b0);
        check("en_drop_gnt", int'(gnt4), 0);
        check("en_drop_vld", int'(vld4), 0);
        for (int c = 0; c < 3; c++) step(8'hFF, 1'b0);
        step(8'hFF, 1'b1);
        step(8'hFF, 1'b1);
        pulse_reset(8'h00);

        // random traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset(8'($urandom));
            else step(($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'($urandom),
                      ($urandom_range(0, 9) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
